// File: rtl/text_writer.sv
// text_writer: write-side engine for the 70x30 character text buffer.
// Consumes ASCII bytes over a valid/ready handshake and tracks a cursor.
// Interprets LF, CR, BS and FF control codes.
// Drives the write port of the text RAM (address = row*COLS + col).
module text_writer #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              CLOCK_50,
  input  logic              clrn,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data,
  output logic              wren,
  output logic [4:0]        cur_row,
  output logic [6:0]        cur_col,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS-1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS-1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS-1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE      = 2'd1,
    S_CLR_LINE   = 2'd2,
    S_CLR_SCREEN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          row_q, row_d;
  logic [6:0]          col_q, col_d;
  logic                adv_pend_q, adv_pend_d;   // line advance owed after WRITE
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_last_q, clr_last_d;   // last clear write has been issued
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                accept_s;
  logic                printable_s;
  logic [ADDR_W-1:0]   cur_addr_s;
  logic [ADDR_W-1:0]   row_base_s;
  logic [4:0]          next_row_s;

  assign accept_s    = char_valid && ready_q;
  assign printable_s = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign row_base_s  = ADDR_W'(row_q) * COLS_A;
  assign cur_addr_s  = row_base_s + ADDR_W'(col_q);
  assign next_row_s  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  // State register; reset starts a full screen clear.
  always_ff @(posedge CLOCK_50 or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_CLR_SCREEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (printable_s) begin
            state_d = S_WRITE;
          end else if (char_data == CH_LF) begin
            state_d = S_CLR_LINE;
          end else if (char_data == CH_BS) begin
            state_d = (col_q != 7'd0) ? S_WRITE : S_IDLE;
          end else if (char_data == CH_FF) begin
            state_d = S_CLR_SCREEN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = adv_pend_q ? S_CLR_LINE : S_IDLE;
      end
      S_CLR_LINE: begin
        state_d = clr_last_q ? S_IDLE : S_CLR_LINE;
      end
      S_CLR_SCREEN: begin
        state_d = clr_last_q ? S_IDLE : S_CLR_SCREEN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values for cursor, clear counter and the registered RAM write port.
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    adv_pend_d = adv_pend_q;
    clr_cnt_d  = clr_cnt_q;
    clr_last_d = 1'b0;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (printable_s) begin
            wren_d = 1'b1;
            addr_d = cur_addr_s;
            data_d = char_data;
            if (col_q < LAST_COL) begin
              col_d      = col_q + 7'd1;
              adv_pend_d = 1'b0;
            end else begin
              col_d      = 7'd0;
              row_d      = next_row_s;
              adv_pend_d = 1'b1;
            end
          end else if (char_data == CH_LF) begin
            col_d     = 7'd0;
            row_d     = next_row_s;
            clr_cnt_d = '0;
          end else if (char_data == CH_CR) begin
            col_d = 7'd0;
          end else if (char_data == CH_BS) begin
            if (col_q != 7'd0) begin
              col_d      = col_q - 7'd1;
              wren_d     = 1'b1;
              addr_d     = cur_addr_s - ADDR_W'(1);
              data_d     = 8'h00;
              adv_pend_d = 1'b0;
            end else begin
              col_d = col_q;
            end
          end else if (char_data == CH_FF) begin
            clr_cnt_d = '0;
          end else begin
            col_d = col_q;
          end
        end else begin
          col_d = col_q;
        end
      end
      S_WRITE: begin
        adv_pend_d = 1'b0;
        clr_cnt_d  = '0;
      end
      S_CLR_LINE: begin
        if (!clr_last_q) begin
          wren_d     = 1'b1;
          addr_d     = row_base_s + clr_cnt_q;
          data_d     = 8'h00;
          clr_last_d = (clr_cnt_q == LINE_LAST);
          clr_cnt_d  = (clr_cnt_q == LINE_LAST) ? clr_cnt_q : clr_cnt_q + ADDR_W'(1);
        end else begin
          clr_cnt_d = '0;
        end
      end
      S_CLR_SCREEN: begin
        if (!clr_last_q) begin
          wren_d     = 1'b1;
          addr_d     = clr_cnt_q;
          data_d     = 8'h00;
          clr_last_d = (clr_cnt_q == LAST_ADDR);
          clr_cnt_d  = (clr_cnt_q == LAST_ADDR) ? clr_cnt_q : clr_cnt_q + ADDR_W'(1);
        end else begin
          clr_cnt_d = '0;
          row_d     = 5'd0;
          col_d     = 7'd0;
        end
      end
      default: begin
        clr_cnt_d = '0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge CLOCK_50 or negedge clrn) begin
    if (!clrn) begin
      row_q      <= 5'd0;
      col_q      <= 7'd0;
      adv_pend_q <= 1'b0;
      clr_cnt_q  <= '0;
      clr_last_q <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      adv_pend_q <= adv_pend_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_last_q <= clr_last_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign char_ready = ready_q;
  assign wraddress  = addr_q;
  assign data       = data_q;
  assign wren       = wren_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected RAM writes are queued by the
// stimulus; a monitor pops and compares each write the DUT issues.
module tb_text_writer;

  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  logic              CLOCK_50;
  logic              clrn;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic [ADDR_W-1:0] wraddress;
  logic [7:0]        data;
  logic              wren;
  logic [4:0]        cur_row;
  logic [6:0]        cur_col;
  logic              busy;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .CLOCK_50   (CLOCK_50),
    .clrn       (clrn),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wraddress  (wraddress),
    .data       (data),
    .wren       (wren),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  int n_cmp;
  int n_bad;
  logic [19:0] exp_q[$];   // {addr[11:0], data[7:0]}

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int addr, input int val);
    exp_q.push_back({12'(addr), 8'(val)});
  endtask

  task automatic push_row_clear(input int r);
    for (int c = 0; c < COLS; c++) push_wr(r*COLS + c, 0);
  endtask

  task automatic push_screen_clear(input int last);
    for (int a = 0; a <= last; a++) push_wr(a, 0);
  endtask

  // Monitor: compares every RAM write against the scoreboard head.
  task automatic run_monitor();
    logic [19:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (wren) begin
        chk("busy_during_wren", int'(busy), 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", wraddress, data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(wraddress), int'(e[19:8]));
          chk("wr_data", int'(data), int'(e[7:0]));
        end
      end
    end
  endtask

  // Offer one byte and hold it until the DUT consumes it.
  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge CLOCK_50);
    char_valid = 1'b1;
    char_data  = b;
    k = 0;
    while (!char_ready && k < 5000) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (!char_ready) begin
      chk("ready_timeout", 0, 1);
      char_valid = 1'b0;
    end else begin
      @(posedge CLOCK_50);
      #1;
      char_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge CLOCK_50);
    while (!(char_ready && !wren) && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (!(char_ready && !wren)) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_cursor(input string tag, input int r, input int c);
    chk({tag, "_row"}, int'(cur_row), r);
    chk({tag, "_col"}, int'(cur_col), c);
  endtask

  initial begin
    int k;
    n_cmp      = 0;
    n_bad      = 0;
    clrn       = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    fork
      run_monitor();
      begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("rst_wren", int'(wren), 0);
    chk("rst_addr", int'(wraddress), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_ready", int'(char_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk_cursor("rst", 0, 0);

    // Power-up screen clear: 2100 zero writes 0..2099
    push_screen_clear(2099);
    clrn = 1'b1;
    wait_idle(3000);
    chk("clr_screen_drained", exp_q.size(), 0);
    chk("idle_ready", int'(char_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk_cursor("after_clear", 0, 0);

    // "AB" at (0,0)
    push_wr(0, 8'h41);
    send_byte(8'h41);
    @(negedge CLOCK_50);
    chk("ready_low_after_A", int'(char_ready), 0);
    @(negedge CLOCK_50);
    chk("ready_back_after_A", int'(char_ready), 1);
    push_wr(1, 8'h42);
    send_byte(8'h42);
    @(negedge CLOCK_50);
    chk("ready_low_after_B", int'(char_ready), 0);
    @(negedge CLOCK_50);
    chk("ready_back_after_B", int'(char_ready), 1);
    chk_cursor("ab", 0, 2);

    // Move to (3,69): CR, three LFs, 69 printables
    send_byte(8'h0D);
    for (int r = 1; r <= 3; r++) begin
      push_row_clear(r);
      send_byte(8'h0A);
    end
    for (int c = 0; c < 69; c++) begin
      push_wr(3*COLS + c, 8'h21 + c);
      send_byte(8'(8'h21 + c));
    end
    wait_idle(200);
    chk_cursor("pre_wrap", 3, 69);

    // Row wrap: 'Z' at 279, then row 4 cleared 280..349
    push_wr(279, 8'h5A);
    push_row_clear(4);
    send_byte(8'h5A);
    wait_idle(300);
    chk("row_wrap_drained", exp_q.size(), 0);
    chk_cursor("row_wrap", 4, 0);

    // Move to (29,5)
    for (int r = 5; r <= 29; r++) begin
      push_row_clear(r);
      send_byte(8'h0A);
    end
    for (int c = 0; c < 5; c++) begin
      push_wr(29*COLS + c, 8'h61 + c);
      send_byte(8'(8'h61 + c));
    end
    wait_idle(200);
    chk_cursor("pre_screen_wrap", 29, 5);

    // LF on last row wraps to row 0 and clears it
    push_row_clear(0);
    send_byte(8'h0A);
    wait_idle(300);
    chk("screen_wrap_drained", exp_q.size(), 0);
    chk_cursor("screen_wrap", 0, 0);

    // CR at (0,0): no write, cursor unchanged
    send_byte(8'h0D);
    repeat (4) @(negedge CLOCK_50);
    chk_cursor("cr_at_origin", 0, 0);

    // Backspace from (2,10)
    push_row_clear(1);
    send_byte(8'h0A);
    push_row_clear(2);
    send_byte(8'h0A);
    for (int c = 0; c < 10; c++) begin
      push_wr(2*COLS + c, 8'h30 + c);
      send_byte(8'(8'h30 + c));
    end
    wait_idle(200);
    chk_cursor("pre_bs", 2, 10);
    push_wr(149, 0);
    send_byte(8'h08);
    wait_idle(50);
    chk("bs_drained", exp_q.size(), 0);
    chk_cursor("bs", 2, 9);
    send_byte(8'h0D);
    send_byte(8'h08);
    repeat (4) @(negedge CLOCK_50);
    chk_cursor("bs_col0", 2, 0);
    chk("bs_col0_idle", int'(char_ready), 1);

    // Form feed
    push_screen_clear(2099);
    send_byte(8'h0C);
    wait_idle(3000);
    chk("ff_drained", exp_q.size(), 0);
    chk_cursor("ff", 0, 0);

    // Reset during a form-feed clear at address 500
    push_wr(0, 8'h51);
    send_byte(8'h51);
    wait_idle(50);
    chk_cursor("pre_ff2", 0, 1);
    push_screen_clear(500);
    send_byte(8'h0C);
    k = 0;
    while (!(wren && wraddress == 12'd500) && k < 3000) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk("reached_addr_500", int'(wren && wraddress == 12'd500), 1);
    #1;
    clrn = 1'b0;
    #1;
    chk("midrst_wren", int'(wren), 0);
    chk("midrst_addr", int'(wraddress), 0);
    chk("midrst_ready", int'(char_ready), 0);
    chk("midrst_busy", int'(busy), 1);
    chk_cursor("midrst", 0, 0);
    chk("midrst_drained", exp_q.size(), 0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    push_screen_clear(2099);
    clrn = 1'b1;
    wait_idle(3000);
    chk("restart_drained", exp_q.size(), 0);
    chk_cursor("restart", 0, 0);

    // Ignored control byte 0x07
    send_byte(8'h07);
    repeat (4) @(negedge CLOCK_50);
    chk_cursor("bell", 0, 0);
    chk("bell_ready", int'(char_ready), 1);
    chk("bell_busy", int'(busy), 0);
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
